// File: rtl/lru_access_ctrl_lv1_pkg.sv
// Shared types and constants for the L1 LRU access front-end.
// The state enum is shared so the bench can decode the debug state output.
package lv1_lru_pkg;

    localparam int LV1_NUM_WAYS  = 4;
    localparam int LV1_ASSOC_WID = 2;

    // blk_accessed_main encodings understood by the pseudo-LRU block
    localparam logic [2:0] LRU_CMD_CLEAR     = 3'b100;
    localparam logic       LRU_CMD_TOUCH_MSB = 1'b0;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        TOUCH      = 3'd2,
        VICTIM     = 3'd3,
        WAIT_FILL  = 3'd4,
        FILL_TOUCH = 3'd5
    } lv1_state_e;

endpackage

// File: rtl/lru_access_ctrl_lv1_if.sv
// Bus between the L1 cache controller / LRU block and the LRU access front-end.
// Handshake: an access transfers on a rising edge where access_valid && ready;
// the controller holds access_valid and its fields stable until that edge.
interface lru_access_ctrl_lv1_if #(
    parameter int IDX_W     = 2,
    parameter int ASSOC_WID = 2
);
    logic                 access_valid;
    logic                 access_hit;
    logic [IDX_W-1:0]     access_index;
    logic [ASSOC_WID-1:0] access_way;
    logic [3:0]           set_valid;
    logic                 fill_done;
    logic [ASSOC_WID-1:0] lru_replacement_proc;
    logic                 ready;
    logic                 victim_valid;
    logic [ASSOC_WID-1:0] victim_way;
    logic [IDX_W-1:0]     index_proc;
    logic [2:0]           blk_accessed_main;
    logic                 lru_upd_en;

    modport slave (
        input  access_valid, access_hit, access_index, access_way,
        input  set_valid, fill_done, lru_replacement_proc,
        output ready, victim_valid, victim_way, index_proc,
        output blk_accessed_main, lru_upd_en
    );

    modport master (
        output access_valid, access_hit, access_index, access_way,
        output set_valid, fill_done, lru_replacement_proc,
        input  ready, victim_valid, victim_way, index_proc,
        input  blk_accessed_main, lru_upd_en
    );
endinterface

// File: rtl/lru_access_ctrl_lv1_invalid_way_pick.sv
// Priority encoder: reports whether any way of a set is invalid and which
// invalid way has the lowest number.
module lv1_invalid_way_pick
    import lv1_lru_pkg::*;
#(
    parameter int ASSOC_WID = LV1_ASSOC_WID
) (
    input  logic [LV1_NUM_WAYS-1:0] i_set_valid,
    output logic                    o_any_invalid,
    output logic [ASSOC_WID-1:0]    o_way
);

    assign o_any_invalid = ~(&i_set_valid);

    // Scan from the top so the lowest invalid way is the last one written.
    always_comb begin
        o_way = '0;
        for (int w = LV1_NUM_WAYS - 1; w >= 0; w--) begin
            if (!i_set_valid[w]) o_way = ASSOC_WID'(w);
        end
    end

endmodule

// File: rtl/lru_access_ctrl_lv1.sv
// L1 LRU access front-end: sweeps all sets clear at init, turns hit/miss
// events into touch commands and picks a victim on a miss.
module lru_access_ctrl_lv1
    import lv1_lru_pkg::*;
#(
    parameter int ASSOC_WID   = LV1_ASSOC_WID,
    parameter int INDEX_MSB   = 1,
    parameter int INDEX_LSB   = 0,
    parameter int NUM_OF_SETS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    lru_access_ctrl_lv1_if.slave  bus,
    output lv1_state_e            o_dbg_state
);

    localparam int IDX_W = INDEX_MSB - INDEX_LSB + 1;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_OF_SETS - 1);

    lv1_state_e           r_state;
    lv1_state_e           w_next;
    logic [IDX_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [ASSOC_WID-1:0] r_way;
    logic [ASSOC_WID-1:0] r_victim;
    logic [2:0]           r_blk_last;
    logic [2:0]           w_blk;
    logic                 w_ready;
    logic                 w_upd_en;
    logic                 w_victim_valid;
    logic                 w_accept;
    logic                 w_any_invalid;
    logic [ASSOC_WID-1:0] w_low_invalid;
    logic [ASSOC_WID-1:0] w_victim_sel;

    lv1_invalid_way_pick #(.ASSOC_WID(ASSOC_WID)) u_pick (
        .i_set_valid   (bus.set_valid),
        .o_any_invalid (w_any_invalid),
        .o_way         (w_low_invalid)
    );

    assign w_accept     = bus.access_valid && (r_state == IDLE);
    assign w_victim_sel = w_any_invalid ? w_low_invalid : bus.lru_replacement_proc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_blk          = r_blk_last;
        w_ready        = 1'b0;
        w_upd_en       = 1'b0;
        w_victim_valid = 1'b0;
        case (r_state)
            INIT: begin
                w_blk    = LRU_CMD_CLEAR;
                w_upd_en = 1'b1;
                if (r_cnt == LAST_SET) w_next = IDLE;
            end
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept) w_next = bus.access_hit ? TOUCH : VICTIM;
            end
            TOUCH: begin
                w_blk    = {LRU_CMD_TOUCH_MSB, r_way};
                w_upd_en = 1'b1;
                w_next   = IDLE;
            end
            VICTIM: begin
                w_next = WAIT_FILL;
            end
            WAIT_FILL: begin
                w_victim_valid = 1'b1;
                if (bus.fill_done) w_next = FILL_TOUCH;
            end
            FILL_TOUCH: begin
                w_blk    = {LRU_CMD_TOUCH_MSB, r_victim};
                w_upd_en = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = INIT;
        endcase
    end

    // r_idx follows the sweep counter so IDLE keeps showing the last set cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_way      <= '0;
            r_victim   <= '0;
            r_blk_last <= LRU_CMD_CLEAR;
        end else begin
            r_blk_last <= w_blk;
            if (r_state == INIT) begin
                r_cnt <= (r_cnt == LAST_SET) ? '0 : r_cnt + 1'b1;
                r_idx <= r_cnt;
            end
            if (w_accept) begin
                r_idx <= bus.access_index;
                r_way <= bus.access_way;
            end
            if (r_state == VICTIM) r_victim <= w_victim_sel;
        end
    end

    assign bus.ready             = w_ready;
    assign bus.victim_valid      = w_victim_valid;
    assign bus.victim_way        = r_victim;
    assign bus.index_proc        = (r_state == INIT) ? r_cnt : r_idx;
    assign bus.blk_accessed_main = w_blk;
    assign bus.lru_upd_en        = w_upd_en;
    assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_lru_access_ctrl_lv1.sv
// Directed bench for lru_access_ctrl_lv1: each driver task queues the
// per-cycle outputs the transaction must produce; a negedge process checks them.
module tb_lru_access_ctrl_lv1;
    import lv1_lru_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 2;
    localparam int W  = 6 + AW + IW;

    logic clk;
    logic rst;
    lv1_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    // model of the registered/held outputs
    logic [AW-1:0] m_vway;
    logic [IW-1:0] m_idx;
    logic [2:0]    m_blk;

    lru_access_ctrl_lv1_if #(.IDX_W(IW), .ASSOC_WID(AW)) bus ();

    lru_access_ctrl_lv1 #(
        .ASSOC_WID   (AW),
        .INDEX_MSB   (1),
        .INDEX_LSB   (0),
        .NUM_OF_SETS (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model helpers ----------------
    function automatic logic [W-1:0] mk(logic r, logic vv, logic [AW-1:0] vw,
                                        logic [IW-1:0] idx, logic [2:0] blk, logic upd);
        return {r, vv, vw, idx, blk, upd};
    endfunction

    function automatic logic [AW-1:0] exp_victim(logic [3:0] sv, logic [AW-1:0] lru);
        for (int w = 0; w < 4; w++) begin
            if (sv[w] == 1'b0) return AW'(w);
        end
        return lru;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = mk(bus.ready, bus.victim_valid, bus.victim_way, bus.index_proc,
                   bus.blk_accessed_main, bus.lru_upd_en);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got rdy=%b vv=%b vw=%0d idx=%0d blk=%b upd=%b exp rdy=%b vv=%b vw=%0d idx=%0d blk=%b upd=%b",
                         $time, g[W-1], g[W-2], g[W-3 -: AW], g[3+IW], g[3:1], g[0],
                         e[W-1], e[W-2], e[W-3 -: AW], e[3+IW], e[3:1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle();
        exp_q.push_back(mk(1'b1, 1'b0, m_vway, m_idx, m_blk, 1'b0));
    endtask

    task automatic do_init();
        for (int i = 0; i < N; i++) begin
            if (i > 0) step();
            exp_q.push_back(mk(1'b0, 1'b0, m_vway, IW'(i), 3'b100, 1'b1));
        end
        step();
        m_idx = IW'(N - 1);
        m_blk = 3'b100;
        push_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("rst_victim_way", 32'(bus.victim_way), 32'd0);
        check("rst_index_proc", 32'(bus.index_proc), 32'd0);
        check("rst_blk", 32'(bus.blk_accessed_main), 32'h4);
        check("rst_upd_en", 32'(bus.lru_upd_en), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(INIT));
        rst = 1'b0;
        m_vway = '0;
        m_idx  = '0;
        m_blk  = 3'b100;
        do_init();
    endtask

    task automatic hit(logic [IW-1:0] idx, logic [AW-1:0] way, bit hold);
        bus.access_valid = 1'b1;
        bus.access_hit   = 1'b1;
        bus.access_index = idx;
        bus.access_way   = way;
        step();
        if (!hold) bus.access_valid = 1'b0;
        m_idx = idx;
        m_blk = {1'b0, way};
        exp_q.push_back(mk(1'b0, 1'b0, m_vway, idx, m_blk, 1'b1));
        step();
        push_idle();
    endtask

    task automatic miss(logic [IW-1:0] idx, logic [3:0] sv, logic [AW-1:0] lru,
                        int nwait, bit hold);
        logic [AW-1:0] v;
        bus.access_valid         = 1'b1;
        bus.access_hit           = 1'b0;
        bus.access_index         = idx;
        bus.set_valid            = sv;
        bus.lru_replacement_proc = lru;
        step();
        if (!hold) bus.access_valid = 1'b0;
        m_idx = idx;
        exp_q.push_back(mk(1'b0, 1'b0, m_vway, idx, m_blk, 1'b0));
        v = exp_victim(sv, lru);
        step();
        m_vway = v;
        exp_q.push_back(mk(1'b0, 1'b1, v, idx, m_blk, 1'b0));
        for (int k = 1; k < nwait; k++) begin
            step();
            exp_q.push_back(mk(1'b0, 1'b1, v, idx, m_blk, 1'b0));
        end
        bus.fill_done = 1'b1;
        step();
        bus.fill_done    = 1'b0;
        bus.access_valid = 1'b0;
        m_blk = {1'b0, v};
        exp_q.push_back(mk(1'b0, 1'b0, v, idx, m_blk, 1'b1));
        step();
        push_idle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst                      = 1'b1;
        bus.access_valid         = 1'b0;
        bus.access_hit           = 1'b0;
        bus.access_index         = '0;
        bus.access_way           = '0;
        bus.set_valid            = 4'hF;
        bus.fill_done            = 1'b0;
        bus.lru_replacement_proc = '0;
        m_vway = '0;
        m_idx  = '0;
        m_blk  = 3'b100;

        do_reset();
        check("init_done_ready", 32'(bus.ready), 32'd1);
        check("init_done_idx", 32'(bus.index_proc), 32'd3);

        hit(2'd2, 2'd3, 1'b0);
        check("hit_blk_held", 32'(bus.blk_accessed_main), 32'h3);
        check("hit_idx_held", 32'(bus.index_proc), 32'd2);

        miss(2'd1, 4'b1011, 2'd0, 3, 1'b0);
        check("miss_invalid_way", 32'(bus.victim_way), 32'd2);
        check("miss_invalid_blk", 32'(bus.blk_accessed_main), 32'h2);

        miss(2'd3, 4'b1111, 2'd1, 2, 1'b0);
        check("miss_lru_way", 32'(bus.victim_way), 32'd1);
        check("miss_lru_blk", 32'(bus.blk_accessed_main), 32'h1);

        miss(2'd0, 4'b0000, 2'd3, 1, 1'b1);
        miss(2'd2, 4'b0111, 2'd2, 4, 1'b1);
        check("miss_way3", 32'(bus.victim_way), 32'd3);

        hit(2'd0, 2'd1, 1'b1);
        hit(2'd3, 2'd2, 1'b1);
        hit(2'd1, 2'd0, 1'b0);

        // fill_done while idle must not move the FSM
        bus.fill_done = 1'b1;
        step();
        bus.fill_done = 1'b0;
        push_idle();
        step();
        push_idle();
        check("fill_done_idle_state", 32'(dbg_state), 32'(IDLE));

        // reset in the middle of a miss
        bus.access_valid = 1'b1;
        bus.access_hit   = 1'b0;
        bus.access_index = 2'd2;
        bus.set_valid    = 4'b1101;
        step();
        bus.access_valid = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, m_vway, 2'd2, m_blk, 1'b0));
        step();
        check("mid_miss_victim_valid", 32'(bus.victim_valid), 32'd1);
        check("mid_miss_victim_way", 32'(bus.victim_way), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("rst_async_idx", 32'(bus.index_proc), 32'd0);
        do_reset();

        hit(2'd1, 2'd2, 1'b0);
        miss(2'd3, 4'b1110, 2'd2, 2, 1'b0);
        check("post_rst_miss_way", 32'(bus.victim_way), 32'd0);

        @(negedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
